// File: rtl/wasm_local_frame_mem_pkg.sv
// Shared constants for the WASM local-variable frame store.
// Holds the default geometry (slot width, BRAM depth, frame-stack depth)
// and the clear-FSM state encodings used by wasm_local_frame_mem.
package wasm_local_frame_mem_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_DEPTH      = 256;
  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_MAX_FRAMES = 16;
  localparam int unsigned DEF_FRAME_W    = 4;

  // Clear FSM encodings, kept as plain constants so the state register
  // stays bit-compatible with the legacy block.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_CLEAR = 1'b1;

endpackage

// File: rtl/wasm_local_frame_mem_if.sv
// Local access bus of the frame store (local.get / local.set / local.tee).
// master: CPU side, drives read/write requests.
// slave : frame store, returns registered read data and a valid pulse.
//   rd_en/rd_idx     frame-relative read request
//   rd_data/rd_vld   registered read result, 1-cycle valid pulse
//   wr_en/wr_idx/wr_data  frame-relative write request
interface wasm_local_frame_mem_if
  import wasm_local_frame_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_vld;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output rd_en, rd_idx, wr_en, wr_idx, wr_data,
    input  rd_data, rd_vld
  );

  modport slave (
    input  rd_en, rd_idx, wr_en, wr_idx, wr_data,
    output rd_data, rd_vld
  );

endinterface

// File: rtl/wasm_local_frame_mem_frame_stack.sv
// wasm_frame_stack: LIFO of saved {base, size} frame descriptors.
// Ports:
//   clk, rst              clock, async active-high reset (clears depth only)
//   push, push_base/size  save the caller's frame descriptor
//   pop                   discard the top entry
//   top_base/size         most recently pushed descriptor (valid when !empty)
//   full, empty, depth    occupancy status
// The caller must never push when full or pop when empty, nor do both at once.
module wasm_frame_stack
  import wasm_local_frame_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned MAX_FRAMES = DEF_MAX_FRAMES,
  parameter int unsigned FRAME_W    = DEF_FRAME_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [ADDR_WIDTH:0] push_base,
  input  logic [ADDR_WIDTH:0] push_size,
  input  logic                pop,
  output logic [ADDR_WIDTH:0] top_base,
  output logic [ADDR_WIDTH:0] top_size,
  output logic                full,
  output logic                empty,
  output logic [FRAME_W:0]    depth
);

  localparam logic [FRAME_W:0]   D_ONE = (FRAME_W+1)'(1);
  localparam logic [FRAME_W-1:0] I_ONE = FRAME_W'(1);

  logic [ADDR_WIDTH:0] base_q [MAX_FRAMES];
  logic [ADDR_WIDTH:0] size_q [MAX_FRAMES];
  logic [FRAME_W:0]    depth_q;
  logic [FRAME_W-1:0]  top_idx;

  assign full  = (depth_q == (FRAME_W+1)'(MAX_FRAMES));
  assign empty = (depth_q == '0);
  assign depth = depth_q;

  // MAX_FRAMES is a power of two, so at full depth the low bits wrap to 0
  // and (0 - 1) lands on the last entry.
  assign top_idx  = depth_q[FRAME_W-1:0] - I_ONE;
  assign top_base = base_q[top_idx];
  assign top_size = size_q[top_idx];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      base_q[depth_q[FRAME_W-1:0]] <= push_base;
      size_q[depth_q[FRAME_W-1:0]] <= push_size;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
    end else if (push && !full) begin
      depth_q <= depth_q + D_ONE;
    end else if (pop && !empty) begin
      depth_q <= depth_q - D_ONE;
    end
  end

endmodule

// File: rtl/wasm_local_frame_mem.sv
// wasm_local_frame_mem: WASM function-local store partitioned into call frames.
// One BRAM holds every frame; the current frame is {frame_base, size} and
// callers' frames are saved in wasm_frame_stack. New frames are zero-filled
// one slot per cycle while busy is high.
// Ports:
//   clk, rst         clock, async active-high reset
//   bus (slave)      local.get/set/tee access, frame-relative indices,
//                    1-cycle registered read, read-first on same-slot collision
//   call_req/call_nlocals  push a frame of call_nlocals slots
//   ret_req          pop the current frame
//   busy             frame clear in progress (all requests ignored)
//   frame_depth      nesting depth
//   frame_base       absolute base of the current frame
//   err_overflow     sticky: call rejected or call+ret collision
//   err_underflow    sticky: ret at depth 0
//   err_oob          sticky: access index >= current frame size
module wasm_local_frame_mem
  import wasm_local_frame_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned MAX_FRAMES = DEF_MAX_FRAMES,
  parameter int unsigned FRAME_W    = DEF_FRAME_W
) (
  input  logic                    clk,
  input  logic                    rst,
  wasm_local_frame_mem_if.slave   bus,
  input  logic                    call_req,
  input  logic [ADDR_WIDTH:0]     call_nlocals,
  input  logic                    ret_req,
  output logic                    busy,
  output logic [FRAME_W:0]        frame_depth,
  output logic [ADDR_WIDTH:0]     frame_base,
  output logic                    err_overflow,
  output logic                    err_underflow,
  output logic                    err_oob
);

  localparam logic [ADDR_WIDTH:0] A_ONE = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t              state_q;
  logic [ADDR_WIDTH:0] base_q;
  logic [ADDR_WIDTH:0] size_q;
  logic [ADDR_WIDTH:0] clr_cnt_q;

  logic                idle;
  logic                rd_ok, wr_ok;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr, clr_addr;
  logic [ADDR_WIDTH+1:0] call_end;
  logic                call_fits;
  logic                call_only, ret_only, call_ret_clash;
  logic                call_ok, call_rej, ret_ok, ret_rej;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                stk_full, stk_empty;
  logic [ADDR_WIDTH:0] stk_top_base, stk_top_size;

  assign idle = (state_q == ST_IDLE);
  assign busy = (state_q == ST_CLEAR);

  // Bounds are checked on the full-width index; once in bounds the
  // address is below DEPTH, so the truncated sum is exact.
  assign rd_ok    = ({1'b0, bus.rd_idx} < size_q);
  assign wr_ok    = ({1'b0, bus.wr_idx} < size_q);
  assign rd_addr  = base_q[ADDR_WIDTH-1:0] + bus.rd_idx;
  assign wr_addr  = base_q[ADDR_WIDTH-1:0] + bus.wr_idx;
  assign clr_addr = base_q[ADDR_WIDTH-1:0] + clr_cnt_q[ADDR_WIDTH-1:0];

  assign call_end  = {1'b0, base_q} + {1'b0, size_q} + {1'b0, call_nlocals};
  assign call_fits = (call_end <= (ADDR_WIDTH+2)'(DEPTH));

  assign call_only      = idle && call_req && !ret_req;
  assign ret_only       = idle && ret_req && !call_req;
  assign call_ret_clash = idle && call_req && ret_req;
  assign call_ok  = call_only && !stk_full && call_fits;
  assign call_rej = call_only && !call_ok;
  assign ret_ok   = ret_only && !stk_empty;
  assign ret_rej  = ret_only && stk_empty;

  wasm_frame_stack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_FRAMES (MAX_FRAMES),
    .FRAME_W    (FRAME_W)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (call_ok),
    .push_base (base_q),
    .push_size (size_q),
    .pop       (ret_ok),
    .top_base  (stk_top_base),
    .top_size  (stk_top_size),
    .full      (stk_full),
    .empty     (stk_empty),
    .depth     (frame_depth)
  );

  assign frame_base = base_q;

  // Single write port shared by the clear sweep and local.set/tee.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = bus.wr_data;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (bus.wr_en && wr_ok) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_data <= '0;
      bus.rd_vld  <= 1'b0;
    end else begin
      bus.rd_vld <= idle && bus.rd_en;
      if (idle && bus.rd_en) begin
        bus.rd_data <= rd_ok ? mem[rd_addr] : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      size_q    <= '0;
      clr_cnt_q <= '0;
    end else if (busy) begin
      clr_cnt_q <= clr_cnt_q + A_ONE;
      if (clr_cnt_q == size_q - A_ONE) begin
        state_q <= ST_IDLE;
      end
    end else if (call_ok) begin
      base_q    <= base_q + size_q;
      size_q    <= call_nlocals;
      clr_cnt_q <= '0;
      if (call_nlocals != '0) begin
        state_q <= ST_CLEAR;
      end
    end else if (ret_ok) begin
      base_q <= stk_top_base;
      size_q <= stk_top_size;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_oob       <= 1'b0;
    end else begin
      if (call_rej || call_ret_clash) err_overflow <= 1'b1;
      if (ret_rej) err_underflow <= 1'b1;
      if (idle && ((bus.rd_en && !rd_ok) || (bus.wr_en && !wr_ok))) err_oob <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wasm_local_frame_mem.sv
module tb_wasm_local_frame_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        call_req = 1'b0;
  logic [8:0]  call_nlocals = '0;
  logic        ret_req = 1'b0;
  logic        busy;
  logic [4:0]  frame_depth;
  logic [8:0]  frame_base;
  logic        err_overflow, err_underflow, err_oob;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wasm_local_frame_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  wasm_local_frame_mem #(
    .DATA_WIDTH (32),
    .DEPTH      (256),
    .ADDR_WIDTH (8),
    .MAX_FRAMES (16),
    .FRAME_W    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .call_req      (call_req),
    .call_nlocals  (call_nlocals),
    .ret_req       (ret_req),
    .busy          (busy),
    .frame_depth   (frame_depth),
    .frame_base    (frame_base),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_oob       (err_oob)
  );

  // Reference model: memory array, frame list as queues, busy countdown.
  logic [31:0] mm [256];
  int   mbase, msize, mdepth, mbusy;
  int   qb[$];
  int   qs[$];
  bit   e_ovf, e_unf, e_oob, exp_vld;
  logic [31:0] exp_data;

  function automatic void model_reset();
    mbase = 0; msize = 0; mdepth = 0; mbusy = 0;
    qb.delete(); qs.delete();
    e_ovf = 0; e_unf = 0; e_oob = 0; exp_vld = 0; exp_data = '0;
  endfunction

  function automatic void model_step(input bit re, input int ri, input bit we, input int wi,
                                     input logic [31:0] wd, input bit c, input int n, input bit r);
    exp_vld = 0;
    if (mbusy > 0) begin
      mbusy--;
      return;
    end
    if (re) begin
      exp_vld = 1;
      if (ri < msize) exp_data = mm[mbase + ri];
      else begin exp_data = '0; e_oob = 1; end
    end
    if (we) begin
      if (wi < msize) mm[mbase + wi] = wd;
      else e_oob = 1;
    end
    if (c && r) e_ovf = 1;
    else if (c) begin
      if (mdepth == 16 || mbase + msize + n > 256) e_ovf = 1;
      else begin
        qb.push_back(mbase); qs.push_back(msize);
        mbase = mbase + msize; msize = n; mdepth++;
        for (int k = 0; k < n; k++) mm[mbase + k] = '0;
        mbusy = n;
      end
    end else if (r) begin
      if (mdepth == 0) e_unf = 1;
      else begin
        mbase = qb.pop_back(); msize = qs.pop_back(); mdepth--;
      end
    end
  endfunction

  task automatic cycle(input bit re, input int ri, input bit we, input int wi,
                       input logic [31:0] wd, input bit c, input int n, input bit r);
    bus.rd_en = re; bus.rd_idx = ri[7:0];
    bus.wr_en = we; bus.wr_idx = wi[7:0]; bus.wr_data = wd;
    call_req = c; call_nlocals = n[8:0]; ret_req = r;
    @(posedge clk);
    model_step(re, ri, we, wi, wd, c, n, r);
    #1;
    bus.rd_en = 0; bus.wr_en = 0; call_req = 0; ret_req = 0;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while (busy === 1'b1 && cnt < 400) begin idle(); cnt++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle busy=%b after %0d cycles, want 0", busy, cnt);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({busy, frame_depth, frame_base, bus.rd_vld, bus.rd_data, err_overflow, err_underflow, err_oob}
        !== '0) begin
      errors++;
      $display("FAIL reset_state busy=%b depth=%0d base=%0d vld=%b data=%h ovf=%b unf=%b oob=%b, want all 0",
               busy, frame_depth, frame_base, bus.rd_vld, bus.rd_data, err_overflow, err_underflow, err_oob);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_call_clear();
    int cnt = 0;
    cycle(0, 0, 0, 0, '0, 1, 4, 0);
    while (busy === 1'b1 && cnt < 20) begin cnt++; idle(); end
    checks++;
    if (cnt != 4) begin errors++; $display("FAIL busy_len got %0d want 4", cnt); end
    checks++;
    if (frame_depth !== 5'd1 || frame_base !== 9'd0) begin
      errors++; $display("FAIL call4_frame depth=%0d base=%0d want 1/0", frame_depth, frame_base);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1, i, 0, 0, '0, 0, 0, 0);
      checks++;
      if (bus.rd_vld !== 1'b1 || bus.rd_data !== 32'h0) begin
        errors++; $display("FAIL clear_read idx%0d vld=%b data=%h want 1/0", i, bus.rd_vld, bus.rd_data);
      end
    end
    idle();
    checks++;
    if (bus.rd_vld !== 1'b0) begin errors++; $display("FAIL rd_vld_pulse got %b want 0", bus.rd_vld); end
  endtask

  task automatic test_rw();
    cycle(0, 0, 1, 2, 32'hDEADBEEF, 0, 0, 0);
    cycle(1, 2, 0, 0, '0, 0, 0, 0);
    checks++;
    if (bus.rd_vld !== 1'b1 || bus.rd_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_read got %h want deadbeef", bus.rd_data);
    end
    cycle(1, 2, 1, 2, 32'h1, 0, 0, 0);
    checks++;
    if (bus.rd_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_first got %h want deadbeef", bus.rd_data);
    end
    cycle(1, 2, 0, 0, '0, 0, 0, 0);
    checks++;
    if (bus.rd_data !== 32'h1) begin errors++; $display("FAIL after_collision got %h want 1", bus.rd_data); end
  endtask

  task automatic test_nested();
    cycle(1, 2, 0, 0, '0, 1, 3, 0);   // read shares the call cycle
    checks++;
    if (bus.rd_vld !== 1'b1 || bus.rd_data !== 32'h1) begin
      errors++; $display("FAIL read_on_call got %h want 1", bus.rd_data);
    end
    wait_idle();
    checks++;
    if (frame_depth !== 5'd2 || frame_base !== 9'd4) begin
      errors++; $display("FAIL nested_frame depth=%0d base=%0d want 2/4", frame_depth, frame_base);
    end
    cycle(0, 0, 1, 0, 32'h55, 0, 0, 0);
    cycle(1, 0, 0, 0, '0, 0, 0, 0);
    checks++;
    if (bus.rd_data !== 32'h55) begin errors++; $display("FAIL inner_write got %h want 55", bus.rd_data); end
    cycle(0, 0, 0, 0, '0, 0, 0, 1);
    checks++;
    if (frame_depth !== 5'd1 || frame_base !== 9'd0) begin
      errors++; $display("FAIL ret_frame depth=%0d base=%0d want 1/0", frame_depth, frame_base);
    end
    cycle(1, 2, 0, 0, '0, 0, 0, 0);
    checks++;
    if (bus.rd_data !== 32'h1) begin errors++; $display("FAIL outer_intact got %h want 1", bus.rd_data); end
    checks++;
    if (err_oob !== 1'b0 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
      errors++; $display("FAIL no_err_yet oob=%b ovf=%b unf=%b want 0", err_oob, err_overflow, err_underflow);
    end
  endtask

  task automatic test_oob();
    cycle(1, 4, 0, 0, '0, 0, 0, 0);
    checks++;
    if (bus.rd_vld !== 1'b1 || bus.rd_data !== 32'h0 || err_oob !== 1'b1) begin
      errors++; $display("FAIL oob_read vld=%b data=%h oob=%b want 1/0/1", bus.rd_vld, bus.rd_data, err_oob);
    end
    cycle(0, 0, 1, 4, 32'h77, 0, 0, 0);
    cycle(0, 0, 0, 0, '0, 1, 2, 0);
    wait_idle();
    cycle(1, 0, 0, 0, '0, 0, 0, 0);
    checks++;
    if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL new_slot4 got %h want 0", bus.rd_data); end
    // base 4 + idx 254 would alias outer slot 2 if the write were not suppressed
    cycle(0, 0, 1, 254, 32'hBAD, 0, 0, 0);
    cycle(0, 0, 0, 0, '0, 0, 0, 1);
    cycle(1, 2, 0, 0, '0, 0, 0, 0);
    checks++;
    if (bus.rd_data !== 32'h1) begin errors++; $display("FAIL oob_write_alias got %h want 1", bus.rd_data); end
  endtask

  task automatic test_errors();
    do_reset();
    cycle(0, 0, 0, 0, '0, 0, 0, 1);
    checks++;
    if (err_underflow !== 1'b1 || err_overflow !== 1'b0 || frame_depth !== 5'd0) begin
      errors++; $display("FAIL underflow unf=%b ovf=%b depth=%0d want 1/0/0", err_underflow, err_overflow, frame_depth);
    end
    cycle(0, 0, 0, 0, '0, 1, 300, 0);
    checks++;
    if (err_overflow !== 1'b1 || frame_depth !== 5'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL call300 ovf=%b depth=%0d busy=%b want 1/0/0", err_overflow, frame_depth, busy);
    end
    do_reset();
    cycle(0, 0, 0, 0, '0, 1, 2, 1);
    checks++;
    if (err_overflow !== 1'b1 || err_underflow !== 1'b0 || frame_depth !== 5'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL call_ret_clash ovf=%b unf=%b depth=%0d busy=%b want 1/0/0/0",
                         err_overflow, err_underflow, frame_depth, busy);
    end
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, 0, '0, 1, 1, 0);
      wait_idle();
    end
    checks++;
    if (frame_depth !== 5'd16 || err_overflow !== 1'b0 || frame_base !== 9'd15) begin
      errors++; $display("FAIL depth16 depth=%0d ovf=%b base=%0d want 16/0/15", frame_depth, err_overflow, frame_base);
    end
    cycle(0, 0, 0, 0, '0, 1, 1, 0);
    checks++;
    if (frame_depth !== 5'd16 || err_overflow !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL call17 depth=%0d ovf=%b busy=%b want 16/1/0", frame_depth, err_overflow, busy);
    end
    do_reset();
    cycle(0, 0, 0, 0, '0, 1, 256, 0);
    wait_idle();
    cycle(0, 0, 0, 0, '0, 1, 1, 0);
    checks++;
    if (err_overflow !== 1'b1 || frame_depth !== 5'd1 || frame_base !== 9'd0) begin
      errors++; $display("FAIL bram_full ovf=%b depth=%0d base=%0d want 1/1/0", err_overflow, frame_depth, frame_base);
    end
    do_reset();
    cycle(0, 0, 0, 0, '0, 1, 256, 0);
    wait_idle();
    cycle(0, 0, 0, 0, '0, 1, 0, 0);
    checks++;
    if (err_overflow !== 1'b0 || frame_depth !== 5'd2 || frame_base !== 9'd256 || busy !== 1'b0) begin
      errors++; $display("FAIL empty_frame_at_top ovf=%b depth=%0d base=%0d busy=%b want 0/2/256/0",
                         err_overflow, frame_depth, frame_base, busy);
    end
    cycle(1, 0, 0, 0, '0, 0, 0, 0);
    checks++;
    if (bus.rd_vld !== 1'b1 || bus.rd_data !== 32'h0 || err_oob !== 1'b1) begin
      errors++; $display("FAIL empty_frame_read vld=%b data=%h oob=%b want 1/0/1", bus.rd_vld, bus.rd_data, err_oob);
    end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    cycle(0, 0, 0, 0, '0, 0, 0, 1);
    cycle(0, 0, 0, 0, '0, 1, 100, 0);
    repeat (10) idle();
    checks++;
    if (busy !== 1'b1 || frame_depth !== 5'd1 || err_underflow !== 1'b1) begin
      errors++; $display("FAIL mid_clear busy=%b depth=%0d unf=%b want 1/1/1", busy, frame_depth, err_underflow);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, frame_depth, frame_base, bus.rd_vld, err_overflow, err_underflow, err_oob} !== '0) begin
      errors++; $display("FAIL async_reset busy=%b depth=%0d base=%0d vld=%b ovf=%b unf=%b oob=%b want all 0",
                         busy, frame_depth, frame_base, bus.rd_vld, err_overflow, err_underflow, err_oob);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    checks++;
    if (busy !== 1'b0 || frame_depth !== 5'd0) begin
      errors++; $display("FAIL post_reset_idle busy=%b depth=%0d want 0/0", busy, frame_depth);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bit re, we, c, r;
      int ri, wi, n, lim;
      logic [31:0] wd;
      lim = (msize > 0) ? msize + 1 : 2;
      re = ($urandom_range(0, 2) == 0);
      we = ($urandom_range(0, 2) == 0);
      ri = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, lim - 1);
      wi = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, lim - 1);
      wd = $urandom;
      c  = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 9) == 0);
      n  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 300) : $urandom_range(0, 12);
      cycle(re, ri, we, wi, wd, c, n, r);
      checks++;
      if (bus.rd_vld !== exp_vld || (exp_vld && bus.rd_data !== exp_data)) begin
        errors++; $display("FAIL rand_read cyc%0d vld=%b data=%h want %b/%h", i, bus.rd_vld, bus.rd_data, exp_vld, exp_data);
      end
      checks++;
      if (busy !== (mbusy > 0) || frame_depth !== 5'(mdepth) || frame_base !== 9'(mbase)) begin
        errors++; $display("FAIL rand_frame cyc%0d busy=%b depth=%0d base=%0d want %0d/%0d/%0d",
                           i, busy, frame_depth, frame_base, mbusy > 0, mdepth, mbase);
      end
      checks++;
      if ({err_overflow, err_underflow, err_oob} !== {e_ovf, e_unf, e_oob}) begin
        errors++; $display("FAIL rand_err cyc%0d ovf/unf/oob=%b%b%b want %b%b%b",
                           i, err_overflow, err_underflow, err_oob, e_ovf, e_unf, e_oob);
      end
      if ((i % 300) == 299) do_reset();
    end
  endtask

  initial begin
    bus.rd_en = 0; bus.rd_idx = '0; bus.wr_en = 0; bus.wr_idx = '0; bus.wr_data = '0;
    test_reset();
    test_call_clear();
    test_rw();
    test_nested();
    test_oob();
    test_errors();
    test_reset_mid_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
